// File: rtl/ps2_kbd_pkg.sv
// ============================================================================
// Module   : ps2_kbd_pkg
// Purpose  : Shared constants, decoder state encoding and key-event record
//            for the PS/2 Set-2 scan-code decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_kbd_pkg;

    localparam logic [7:0] c_pfx_ext   = 8'hE0;
    localparam logic [7:0] c_pfx_brk   = 8'hF0;
    localparam logic [7:0] c_pfx_pause = 8'hE1;

    localparam logic [7:0] c_dsc_bat    = 8'hAA;
    localparam logic [7:0] c_dsc_ack    = 8'hFA;
    localparam logic [7:0] c_dsc_resend = 8'hFE;
    localparam logic [7:0] c_dsc_echo   = 8'hEE;
    localparam logic [7:0] c_dsc_err0   = 8'h00;
    localparam logic [7:0] c_dsc_err1   = 8'hFF;

    localparam logic [7:0] c_key_lshift = 8'h12;
    localparam logic [7:0] c_key_rshift = 8'h59;
    localparam logic [7:0] c_key_ctrl   = 8'h14;
    localparam logic [7:0] c_key_alt    = 8'h11;
    localparam logic [7:0] c_key_caps   = 8'h58;

    localparam logic [7:0] c_key_kp_slash = 8'h4A;
    localparam logic [7:0] c_key_kp_enter = 8'h5A;

    // Bytes that trail the E1 of the Pause sequence
    localparam logic [2:0] c_pause_skip = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } dec_state_t;

    typedef struct packed {
        logic [7:0] scan;
        logic [7:0] code;
        logic       brk;
        logic       ext;
        logic [3:0] mods;
    } kbd_event_t;

    function automatic logic is_discard(input logic [7:0] b);
        return (b == c_dsc_bat)  || (b == c_dsc_ack)  || (b == c_dsc_resend) ||
               (b == c_dsc_echo) || (b == c_dsc_err0) || (b == c_dsc_err1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_ascii_rom.sv
// ============================================================================
// Module   : ps2_ascii_rom
// Purpose  : Combinational Set-2 scan code to ASCII table (unshifted, shifted,
//            letter flag). Unknown codes map to 8'h00.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_ascii_rom (
    input  logic [7:0] i_scan,
    output logic [7:0] o_unshifted,
    output logic [7:0] o_shifted,
    output logic       o_is_letter
);

    logic [7:0] w_letter;

    always_comb begin
        w_letter = 8'h00;
        case (i_scan)
            8'h1C: w_letter = 8'h61;  8'h32: w_letter = 8'h62;
            8'h21: w_letter = 8'h63;  8'h23: w_letter = 8'h64;
            8'h24: w_letter = 8'h65;  8'h2B: w_letter = 8'h66;
            8'h34: w_letter = 8'h67;  8'h33: w_letter = 8'h68;
            8'h43: w_letter = 8'h69;  8'h3B: w_letter = 8'h6A;
            8'h42: w_letter = 8'h6B;  8'h4B: w_letter = 8'h6C;
            8'h3A: w_letter = 8'h6D;  8'h31: w_letter = 8'h6E;
            8'h44: w_letter = 8'h6F;  8'h4D: w_letter = 8'h70;
            8'h15: w_letter = 8'h71;  8'h2D: w_letter = 8'h72;
            8'h1B: w_letter = 8'h73;  8'h2C: w_letter = 8'h74;
            8'h3C: w_letter = 8'h75;  8'h2A: w_letter = 8'h76;
            8'h1D: w_letter = 8'h77;  8'h22: w_letter = 8'h78;
            8'h35: w_letter = 8'h79;  8'h1A: w_letter = 8'h7A;
            default: w_letter = 8'h00;
        endcase
    end

    always_comb begin
        o_unshifted = 8'h00;
        o_shifted   = 8'h00;
        o_is_letter = 1'b0;
        if (w_letter != 8'h00) begin
            o_unshifted = w_letter;
            o_shifted   = w_letter & 8'hDF;
            o_is_letter = 1'b1;
        end else begin
            case (i_scan)
                8'h45: begin o_unshifted = 8'h30; o_shifted = 8'h29; end
                8'h16: begin o_unshifted = 8'h31; o_shifted = 8'h21; end
                8'h1E: begin o_unshifted = 8'h32; o_shifted = 8'h40; end
                8'h26: begin o_unshifted = 8'h33; o_shifted = 8'h23; end
                8'h25: begin o_unshifted = 8'h34; o_shifted = 8'h24; end
                8'h2E: begin o_unshifted = 8'h35; o_shifted = 8'h25; end
                8'h36: begin o_unshifted = 8'h36; o_shifted = 8'h5E; end
                8'h3D: begin o_unshifted = 8'h37; o_shifted = 8'h26; end
                8'h3E: begin o_unshifted = 8'h38; o_shifted = 8'h2A; end
                8'h46: begin o_unshifted = 8'h39; o_shifted = 8'h28; end
                8'h0E: begin o_unshifted = 8'h60; o_shifted = 8'h7E; end
                8'h4E: begin o_unshifted = 8'h2D; o_shifted = 8'h5F; end
                8'h55: begin o_unshifted = 8'h3D; o_shifted = 8'h2B; end
                8'h5D: begin o_unshifted = 8'h5C; o_shifted = 8'h7C; end
                8'h54: begin o_unshifted = 8'h5B; o_shifted = 8'h7B; end
                8'h5B: begin o_unshifted = 8'h5D; o_shifted = 8'h7D; end
                8'h4C: begin o_unshifted = 8'h3B; o_shifted = 8'h3A; end
                8'h52: begin o_unshifted = 8'h27; o_shifted = 8'h22; end
                8'h41: begin o_unshifted = 8'h2C; o_shifted = 8'h3C; end
                8'h49: begin o_unshifted = 8'h2E; o_shifted = 8'h3E; end
                8'h4A: begin o_unshifted = 8'h2F; o_shifted = 8'h3F; end
                8'h29: begin o_unshifted = 8'h20; o_shifted = 8'h20; end
                8'h5A: begin o_unshifted = 8'h0D; o_shifted = 8'h0D; end
                8'h66: begin o_unshifted = 8'h08; o_shifted = 8'h08; end
                8'h0D: begin o_unshifted = 8'h09; o_shifted = 8'h09; end
                8'h76: begin o_unshifted = 8'h1B; o_shifted = 8'h1B; end
                default: begin o_unshifted = 8'h00; o_shifted = 8'h00; end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
// ============================================================================
// Module   : ps2_scancode_decoder
// Purpose  : PS/2 Set-2 byte stream to key events (make/break, extended,
//            modifiers, optional ASCII) buffered in a valid/ready FIFO.
//            Define SCANCODE_ASCII_EN to compile in the ASCII translation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_scancode_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_scan,
    output logic [7:0] ev_code,
    output logic       ev_break,
    output logic       ev_ext,
    output logic [3:0] ev_mods,
    output logic       overflow,
    input  logic       clr_ovf
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dec_state_t r_state, w_state_nxt;
    logic [2:0] r_skip, w_skip_nxt;
    logic       r_lshift, r_rshift, r_ctrl, r_alt, r_caps, r_caps_held;
    logic       w_lshift_nxt, w_rshift_nxt, w_ctrl_nxt, w_alt_nxt;
    logic       w_caps_nxt, w_caps_held_nxt;

    logic       w_emit, w_key, w_brk, w_ext;
    logic [7:0] w_scan, w_code;
    logic [3:0] w_mods;
    logic       w_shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_skip      <= 3'd0;
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_ctrl      <= 1'b0;
            r_alt       <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_skip      <= w_skip_nxt;
            r_lshift    <= w_lshift_nxt;
            r_rshift    <= w_rshift_nxt;
            r_ctrl      <= w_ctrl_nxt;
            r_alt       <= w_alt_nxt;
            r_caps      <= w_caps_nxt;
            r_caps_held <= w_caps_held_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_emit      = 1'b0;
        w_key       = 1'b0;
        w_brk       = 1'b0;
        w_ext       = 1'b0;
        w_scan      = rx_data;
        if (rx_ready) begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_data == c_pfx_ext) begin
                        w_state_nxt = ST_EXT;
                    end else if (rx_data == c_pfx_brk) begin
                        w_state_nxt = ST_BRK;
                    end else if (rx_data == c_pfx_pause) begin
                        w_state_nxt = ST_PAUSE;
                        w_skip_nxt  = c_pause_skip;
                        w_emit      = 1'b1;
                    end else if (!is_discard(rx_data)) begin
                        w_emit = 1'b1;
                        w_key  = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (rx_data == c_pfx_brk) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_emit      = 1'b1;
                        w_key       = 1'b1;
                        w_ext       = 1'b1;
                    end
                end
                ST_BRK: begin
                    w_state_nxt = ST_IDLE;
                    w_emit      = 1'b1;
                    w_key       = 1'b1;
                    w_brk       = 1'b1;
                end
                ST_EXT_BRK: begin
                    w_state_nxt = ST_IDLE;
                    w_emit      = 1'b1;
                    w_key       = 1'b1;
                    w_brk       = 1'b1;
                    w_ext       = 1'b1;
                end
                ST_PAUSE: begin
                    if (r_skip <= 3'd1) begin
                        w_skip_nxt  = 3'd0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_skip_nxt = r_skip - 3'd1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Modifier tracking; the event reports the state after this byte
    always_comb begin
        w_lshift_nxt    = r_lshift;
        w_rshift_nxt    = r_rshift;
        w_ctrl_nxt      = r_ctrl;
        w_alt_nxt       = r_alt;
        w_caps_nxt      = r_caps;
        w_caps_held_nxt = r_caps_held;
        if (w_key) begin
            case (w_scan)
                c_key_lshift: w_lshift_nxt = ~w_brk;
                c_key_rshift: w_rshift_nxt = ~w_brk;
                c_key_ctrl:   w_ctrl_nxt   = ~w_brk;
                c_key_alt:    w_alt_nxt    = ~w_brk;
                c_key_caps: begin
                    if (w_brk) begin
                        w_caps_held_nxt = 1'b0;
                    end else begin
                        if (!r_caps_held) w_caps_nxt = ~r_caps;
                        w_caps_held_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_shift = w_lshift_nxt | w_rshift_nxt;
    assign w_mods  = {w_caps_nxt, w_alt_nxt, w_ctrl_nxt, w_shift};

`ifdef SCANCODE_ASCII_EN
    logic [7:0] w_rom_un, w_rom_sh;
    logic       w_rom_letter;

    ps2_ascii_rom u_ascii_rom (
        .i_scan      (w_scan),
        .o_unshifted (w_rom_un),
        .o_shifted   (w_rom_sh),
        .o_is_letter (w_rom_letter)
    );

    always_comb begin
        w_code = 8'h00;
        if (w_ext) begin
            if (w_scan == c_key_kp_slash)      w_code = 8'h2F;
            else if (w_scan == c_key_kp_enter) w_code = 8'h0D;
        end else if (w_rom_letter) begin
            w_code = (w_shift ^ w_caps_nxt) ? w_rom_sh : w_rom_un;
            if (w_ctrl_nxt) w_code = w_code & 8'h1F;
        end else begin
            w_code = w_shift ? w_rom_sh : w_rom_un;
        end
    end
`else
    assign w_code = 8'h00;
`endif

    // Event FIFO: pointers carry one extra wrap bit to tell full from empty
    kbd_event_t      r_mem [DEPTH];
    kbd_event_t      w_event, w_head;
    logic [c_aw:0]   r_wr_ptr, r_rd_ptr;
    logic            w_full, w_empty, w_pop, w_push, w_drop;
    logic            r_ovf;

    assign w_event = {w_scan, w_code, w_brk, w_ext, w_mods};
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_pop   = ~w_empty & ev_ready;
    assign w_push  = w_emit & (~w_full | w_pop);
    assign w_drop  = w_emit & w_full & ~w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[c_aw-1:0]] <= w_event;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_drop)       r_ovf <= 1'b1;
            else if (clr_ovf) r_ovf <= 1'b0;
        end
    end

    assign w_head   = r_mem[r_rd_ptr[c_aw-1:0]];
    assign ev_valid = ~w_empty;
    assign ev_scan  = w_head.scan;
    assign ev_code  = w_head.code;
    assign ev_break = w_head.brk;
    assign ev_ext   = w_head.ext;
    assign ev_mods  = w_head.mods;
    assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
// ============================================================================
// Module   : tb_ps2_scancode_decoder
// Purpose  : Directed self-checking bench with a key-held/queue reference
//            model for ps2_scancode_decoder (honours SCANCODE_ASCII_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;
`ifdef SCANCODE_ASCII_EN
    localparam bit c_asc = 1'b1;
`else
    localparam bit c_asc = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       ev_ready = 1'b1;
    logic       clr_ovf = 1'b0;
    logic       ev_valid, ev_break, ev_ext, overflow;
    logic [7:0] ev_scan, ev_code;
    logic [3:0] ev_mods;
    logic [21:0] head;

    ps2_scancode_decoder #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_scan  (ev_scan),
        .ev_code  (ev_code),
        .ev_break (ev_break),
        .ev_ext   (ev_ext),
        .ev_mods  (ev_mods),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;
    assign head = {ev_scan, ev_code, ev_break, ev_ext, ev_mods};

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: keys currently held, pending prefixes, expected FIFO
    logic [21:0] m_q[$];
    logic [21:0] got[$];
    bit          m_ovf, m_ext, m_brk, m_caps;
    int          m_skip;
    bit          m_held[256];
    logic [7:0]  t_un[256];
    logic [7:0]  t_sh[256];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h @%0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [21:0] ev(input logic [7:0] s, input logic [7:0] c,
                                       input bit b, input bit x, input logic [3:0] m);
        return {s, c, b, x, m};
    endfunction

    function automatic logic [7:0] lc(input logic [7:0] c);
        return c_asc ? c : 8'h00;
    endfunction

    function automatic logic [7:0] model_code(input logic [7:0] s, input bit x, input logic [3:0] m);
        bit letter, upper;
        logic [7:0] c;
        if (x) return lc((s == 8'h4A) ? 8'h2F : (s == 8'h5A) ? 8'h0D : 8'h00);
        letter = (t_un[s] >= 8'h61) && (t_un[s] <= 8'h7A);
        upper  = letter ? (m[0] ^ m[3]) : m[0];
        c      = upper ? t_sh[s] : t_un[s];
        if (letter && m[1]) c = t_un[s] - 8'h60;   // ctrl-A = 1 .. ctrl-Z = 26
        return lc(c);
    endfunction

    task automatic model_push(input logic [21:0] e, inout bit drop);
        if (m_q.size() < DEPTH) m_q.push_back(e);
        else drop = 1'b1;
    endtask

    task automatic model_key(input logic [7:0] s, input bit b, input bit x, inout bit drop);
        logic [3:0] m;
        if (s == 8'h58 && !b && !m_held[8'h58]) m_caps = ~m_caps;
        m_held[s] = !b;
        m = {m_caps, m_held[8'h11], m_held[8'h14], m_held[8'h12] | m_held[8'h59]};
        model_push(ev(s, model_code(s, x, m), b, x, m), drop);
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, inout bit drop);
        if (m_skip > 0) begin
            m_skip--;
        end else if (m_brk) begin
            model_key(b, 1'b1, m_ext, drop);
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1'b1;
            else model_key(b, 1'b0, 1'b1, drop);
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE1) begin
            m_skip = 7;
            model_push(ev(8'hE1, 8'h00, 1'b0, 1'b0, {m_caps, m_held[8'h11], m_held[8'h14],
                          m_held[8'h12] | m_held[8'h59]}), drop);
        end else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
            model_key(b, 1'b0, 1'b0, drop);
        end
    endtask

    initial begin
        bit drop;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_q.delete();
                m_ovf = 0; m_ext = 0; m_brk = 0; m_caps = 0; m_skip = 0;
                foreach (m_held[i]) m_held[i] = 1'b0;
            end else begin
                drop = 1'b0;
                if (m_q.size() != 0 && ev_ready) void'(m_q.pop_front());
                if (rx_ready) model_byte(rx_data, drop);
                if (drop) m_ovf = 1'b1;
                else if (clr_ovf) m_ovf = 1'b0;
            end
        end
    end

    // Per-cycle comparison of DUT against model
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                check("ev_valid", ev_valid, (m_q.size() != 0));
                if (ev_valid && m_q.size() != 0) check("head", head, m_q[0]);
                check("overflow", overflow, m_ovf);
                if (ev_valid && ev_ready) got.push_back(head);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
    endtask

    task automatic send_bytes(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) send(v[8*(n-1-i) +: 8]);
    endtask

    task automatic idle();
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #3;
            if (!ev_valid) break;
        end
        check("drain_done", ev_valid, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_ready = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
    endtask

    task automatic put(input logic [7:0] s, input logic [7:0] u, input logic [7:0] sh);
        t_un[s] = u;
        t_sh[s] = sh;
    endtask

    initial begin
        logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                     8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                     8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                     8'h35, 8'h1A};
        logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                    8'h3E, 8'h46};
        logic [7:0] dsh [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
                                 8'h2A, 8'h28};
        foreach (t_un[i]) begin t_un[i] = 8'h00; t_sh[i] = 8'h00; end
        for (int i = 0; i < 26; i++) put(letters[i], 8'(8'h61 + i), 8'(8'h41 + i));
        for (int i = 0; i < 10; i++) put(digits[i], 8'(8'h30 + i), dsh[i]);
        put(8'h0E, 8'h60, 8'h7E); put(8'h4E, 8'h2D, 8'h5F); put(8'h55, 8'h3D, 8'h2B);
        put(8'h5D, 8'h5C, 8'h7C); put(8'h54, 8'h5B, 8'h7B); put(8'h5B, 8'h5D, 8'h7D);
        put(8'h4C, 8'h3B, 8'h3A); put(8'h52, 8'h27, 8'h22); put(8'h41, 8'h2C, 8'h3C);
        put(8'h49, 8'h2E, 8'h3E); put(8'h4A, 8'h2F, 8'h3F); put(8'h29, 8'h20, 8'h20);
        put(8'h5A, 8'h0D, 8'h0D); put(8'h66, 8'h08, 8'h08); put(8'h0D, 8'h09, 8'h09);
        put(8'h76, 8'h1B, 8'h1B);

        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", ev_valid, 1'b0);
        check("rst_head", head, 22'h0);
        check("rst_ovf", overflow, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Plain make / break
        got.delete();
        send_bytes(64'h1C_F0_1C, 3); idle(); drain();
        check("t1_count", got.size(), 2);
        check("t1_make", got[0], ev(8'h1C, lc(8'h61), 0, 0, 4'h0));
        check("t1_break", got[1], ev(8'h1C, lc(8'h61), 1, 0, 4'h0));

        // Shift
        got.delete();
        send_bytes(64'h12_1C_F0_12, 4); idle(); drain();
        check("t2_count", got.size(), 3);
        check("t2_shift", got[0], ev(8'h12, 8'h00, 0, 0, 4'h1));
        check("t2_upper", got[1], ev(8'h1C, lc(8'h41), 0, 0, 4'h1));
        check("t2_unshift", got[2], ev(8'h12, 8'h00, 1, 0, 4'h0));

        // Caps lock with typematic repeat, then caps off again
        got.delete();
        send_bytes(64'h58_58_F0_58_1C, 5); idle(); drain();
        check("t3_count", got.size(), 4);
        check("t3_caps", got[0], ev(8'h58, 8'h00, 0, 0, 4'h8));
        check("t3_upper", got[3], ev(8'h1C, lc(8'h41), 0, 0, 4'h8));
        got.delete();
        send_bytes(64'h58_F0_58, 3); idle(); drain();
        check("t3_caps_off", got[1], ev(8'h58, 8'h00, 1, 0, 4'h0));

        // Extended keys
        got.delete();
        send_bytes(64'hE0_75_E0_F0_75_E0_5A, 7); idle(); drain();
        check("t4_count", got.size(), 3);
        check("t4_ext_make", got[0], ev(8'h75, 8'h00, 0, 1, 4'h0));
        check("t4_ext_break", got[1], ev(8'h75, 8'h00, 1, 1, 4'h0));
        check("t4_kp_enter", got[2], ev(8'h5A, lc(8'h0D), 0, 1, 4'h0));

        // Pause sequence
        got.delete();
        send_bytes(64'hE1_14_77_E1_F0_14_F0_77, 8); send(8'h1C); idle(); drain();
        check("t5_count", got.size(), 2);
        check("t5_pause", got[0], ev(8'hE1, 8'h00, 0, 0, 4'h0));
        check("t5_after", got[1], ev(8'h1C, lc(8'h61), 0, 0, 4'h0));

        // Ctrl + letter, discard bytes, ext slash
        got.delete();
        send_bytes(64'h14_1C_F0_14_AA_FA_00_E0, 8); send(8'h4A); idle(); drain();
        check("t6_count", got.size(), 4);
        check("t6_ctrl_a", got[1], ev(8'h1C, lc(8'h01), 0, 0, 4'h2));
        check("t6_kp_slash", got[3], ev(8'h4A, lc(8'h2F), 0, 1, 4'h0));

        // Overflow, clear-vs-drop priority, full with simultaneous pop
        got.delete();
        @(negedge clk); ev_ready = 1'b0;
        send_bytes(64'h1C_32_21_23_24, 5); idle(); #3;
        check("t7_ovf_set", overflow, 1'b1);
        check("t7_head_hold", head, ev(8'h1C, lc(8'h61), 0, 0, 4'h0));
        @(negedge clk); rx_data = 8'h2B; rx_ready = 1'b1; clr_ovf = 1'b1;
        @(negedge clk); rx_ready = 1'b0; clr_ovf = 1'b0; #3;
        check("t7_ovf_keep", overflow, 1'b1);
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0; #3;
        check("t7_ovf_clr", overflow, 1'b0);
        @(negedge clk); ev_ready = 1'b1; rx_data = 8'h34; rx_ready = 1'b1;
        idle(); drain();
        check("t7_count", got.size(), 5);
        check("t7_last_kept", got[3], ev(8'h23, lc(8'h64), 0, 0, 4'h0));
        check("t7_pop_push", got[4], ev(8'h34, lc(8'h67), 0, 0, 4'h0));
        check("t7_ovf_after", overflow, 1'b0);

        // Reset mid-sequence
        send(8'hE0); idle(); do_reset();
        got.delete();
        send(8'h1C); idle(); drain();
        check("t8_count", got.size(), 1);
        check("t8_not_ext", got[0], ev(8'h1C, lc(8'h61), 0, 0, 4'h0));
        send_bytes(64'h12_E1_14, 3); idle(); do_reset();
        got.delete();
        send_bytes(64'h1C_77, 2); idle(); drain();
        check("t9_count", got.size(), 2);
        check("t9_no_shift", got[0], ev(8'h1C, lc(8'h61), 0, 0, 4'h0));
        check("t9_no_pause", got[1], ev(8'h77, 8'h00, 0, 0, 4'h0));

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
